// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM select sequencer.
package tdm_pkg;

  typedef enum logic {IDLE, SCAN} tdm_state_t;

  localparam int NUM_CH_DEFAULT = 4;

endpackage

// File: rtl/tdm_dwell_counter.sv
// Modulo-DWELL cycle counter with enable. 'first' marks count 0 and 'wrap'
// marks count DWELL-1. With DWELL=1 every enabled cycle is both first and
// last, so no register is built.
module tdm_dwell_counter #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic first,
  output logic wrap
);

  generate
    if (DWELL == 1) begin : g_single
      logic unused_ins;
      assign unused_ins = ^{clk, rst_n, en};
      assign first = 1'b1;
      assign wrap  = 1'b1;
    end else begin : g_count
      localparam int CW = $clog2(DWELL);
      logic [CW-1:0] cnt;

      // Count enabled cycles, returning to 0 after DWELL-1.
      // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  cnt <= '0;
        else if (en) cnt <= wrap ? '0 : cnt + 1'b1;
      end

      assign wrap  = (cnt == CW'(DWELL - 1));
      assign first = (cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/tdm_select_sequencer.sv
// Upstream stage of the 4:1 mux / 1:4 demux link. Takes one NUM_CH-bit word
// per valid/ready handshake, holds it on mux_data and steps select_lines over
// channels 0..NUM_CH-1, DWELL cycles each, serialising one word per frame.
// Optional build macro LOOPBACK_CHECK_EN adds a sticky check of the looped-back
// mux output against the held word.
module tdm_select_sequencer
  import tdm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int DWELL  = 1,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] in_data,
  output logic [NUM_CH-1:0] mux_data,
  output logic [SEL_W-1:0]  select_lines,
  output logic              ch_valid,
  output logic              frame_start,
  output logic              frame_done,
  input  logic              mux_serial_in,
  output logic              check_err
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  tdm_state_t       state, state_d;
  logic [SEL_W-1:0] sel;
  logic             scan;
  logic             dwell_first;
  logic             dwell_wrap;
  logic             last_beat;
  logic             accept;

  tdm_dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (scan),
    .first (dwell_first),
    .wrap  (dwell_wrap)
  );

  assign scan      = (state == SCAN);
  assign last_beat = scan & (sel == LAST_SEL) & dwell_wrap;
  // rst_n gates ready so nothing is offered while the block is held in reset.
  assign in_ready  = rst_n & (~scan | last_beat);
  assign accept    = in_valid & in_ready;

  // State register.
  // NOTE: asynchronous active-low reset puts the FSM in IDLE without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state: start a frame on accept, leave SCAN only at a last beat with no new word.
  // NOTE: defaulting state_d first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (last_beat) state_d = accept ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Channel select: advance after each full dwell, wrapping to 0 after the last channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 sel <= '0;
    else if (scan & dwell_wrap) sel <= (sel == LAST_SEL) ? '0 : sel + 1'b1;
  end

  // Word register: load on accept, otherwise hold (including across IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mux_data <= '0;
    else if (accept) mux_data <= in_data;
  end

  assign select_lines = sel;
  assign ch_valid     = scan;
  assign frame_start  = scan & (sel == '0) & dwell_first;
  assign frame_done   = last_beat;

`ifdef LOOPBACK_CHECK_EN
  // Sticky loopback check, sampled in the final dwell cycle of each beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      check_err <= 1'b0;
    else if (scan & dwell_wrap & (mux_serial_in != mux_data[sel]))
      check_err <= 1'b1;
  end
`else
  logic unused_serial;
  assign unused_serial = mux_serial_in;
  assign check_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_select_sequencer.sv
// Self-checking bench: two sequencers (DWELL=1 and DWELL=3) compared each
// cycle against a frame-offset model of the link; a simple mux/demux is
// modelled around the DUTs for the loopback path.
module tb_tdm_select_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       vld   [2];
  logic [3:0] dat   [2];
  logic       rdy_o [2];
  logic       chv_o [2];
  logic       fs_o  [2];
  logic       fd_o  [2];
  logic       err_o [2];
  logic [1:0] sel_o [2];
  logic [3:0] mux_o [2];
  logic       corrupt;
  logic       ser0, ser1;

  // Downstream 4:1 mux, with an optional fault on channel 1 of instance 0.
  assign ser0 = mux_o[0][sel_o[0]] ^ (corrupt & (sel_o[0] == 2'd1));
  assign ser1 = mux_o[1][sel_o[1]];

  tdm_select_sequencer #(.NUM_CH(4), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy_o[0]),
    .in_data(dat[0]), .mux_data(mux_o[0]), .select_lines(sel_o[0]),
    .ch_valid(chv_o[0]), .frame_start(fs_o[0]), .frame_done(fd_o[0]),
    .mux_serial_in(ser0), .check_err(err_o[0])
  );

  tdm_select_sequencer #(.NUM_CH(4), .DWELL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy_o[1]),
    .in_data(dat[1]), .mux_data(mux_o[1]), .select_lines(sel_o[1]),
    .ch_valid(chv_o[1]), .frame_start(fs_o[1]), .frame_done(fd_o[1]),
    .mux_serial_in(ser1), .check_err(err_o[1])
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a frame is just an offset 0..4*D-1 past the accept edge.
  bit         m_active [2];
  int         m_off    [2];
  logic [3:0] m_word   [2];
  bit         m_err    [2];

  function automatic int dw(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit exp_ready(int i);
    return rst_n && (!m_active[i] || m_off[i] == 4 * dw(i) - 1);
  endfunction

  function automatic logic [10:0] exp_vec(int i);
    logic [1:0] s;
    s = m_active[i] ? 2'(m_off[i] / dw(i)) : 2'd0;
    return {exp_ready(i), m_active[i], m_active[i] && m_off[i] == 0,
            m_active[i] && m_off[i] == 4 * dw(i) - 1, s, m_word[i], m_err[i]};
  endfunction

  function automatic logic [10:0] obs_vec(int i);
    return {rdy_o[i], chv_o[i], fs_o[i], fd_o[i], sel_o[i], mux_o[i], err_o[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_off[i] = 0; m_word[i] = '0; m_err[i] = 0;
    end
  endtask

  // One clock: decide accepts, cross the edge, advance the model, land on negedge.
  task automatic tick();
    bit acc [2];
    for (int i = 0; i < 2; i++) acc[i] = vld[i] && exp_ready(i);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
`ifdef LOOPBACK_CHECK_EN
      if (i == 0 && m_active[i] && corrupt && m_off[i] / dw(i) == 1 &&
          m_off[i] % dw(i) == dw(i) - 1)
        m_err[i] = 1;
`endif
      if (acc[i]) begin
        m_active[i] = 1; m_off[i] = 0; m_word[i] = dat[i];
      end else if (m_active[i]) begin
        m_off[i]++;
        if (m_off[i] == 4 * dw(i)) begin m_active[i] = 0; m_off[i] = 0; end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    vld[0] = 0; vld[1] = 0;
    repeat (14) tick();
  endtask

  task automatic test_reset();
    logic [10:0] ev, ov;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      ev = exp_vec(i); ov = obs_vec(i); checks++;
      if (ov !== ev) begin failures++; $display("FAIL reset_state[%0d] got=%b exp=%b", i, ov, ev); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy_o[i] !== 1'b1) begin failures++; $display("FAIL ready_after_reset[%0d] got=%b exp=1", i, rdy_o[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [10:0] ev, ov;
    logic [3:0]  got = '0;
    dat[0] = 4'b1010; vld[0] = 1;
    tick();
    vld[0] = 0;
    for (int c = 1; c <= 5; c++) begin
      ev = exp_vec(0); ov = obs_vec(0); checks++;
      if (ov !== ev) begin failures++; $display("FAIL single_frame cyc=%0d got=%b exp=%b", c, ov, ev); end
      if (c <= 4) got[c-1] = ser0;
      tick();
    end
    checks++;
    if (got !== 4'b1010) begin failures++; $display("FAIL single_serial got=%b exp=1010", got); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ev, ov;
    logic [3:0]  q[$];
    logic [3:0]  got2 = '0;
    int          nacc = 0, nfs = 0, total;
    bit          take;
    q.push_back(4'b1010); q.push_back(4'b0110);
    repeat (6) q.push_back(4'($urandom));
    total = q.size();
    dat[0] = q[0]; vld[0] = 1;
    for (int c = 0; c < 120 && (q.size() > 0 || m_active[0]); c++) begin
      ev = exp_vec(0); ov = obs_vec(0); checks++;
      if (ov !== ev) begin failures++; $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, ov, ev); end
      if (nacc == 2 && chv_o[0]) got2[sel_o[0]] = ser0;
      if (fs_o[0]) nfs++;
      take = vld[0] && exp_ready(0);
      tick();
      if (take) begin
        void'(q.pop_front());
        nacc++;
        if (q.size() > 0) dat[0] = q[0];
        else vld[0] = 0;
      end
    end
    checks++;
    if (q.size() != 0 || m_active[0]) begin failures++; $display("FAIL b2b_timeout left=%0d exp=0", q.size()); end
    checks++;
    if (got2 !== 4'b0110) begin failures++; $display("FAIL b2b_second_word got=%b exp=0110", got2); end
    checks++;
    if (nfs != total) begin failures++; $display("FAIL b2b_frame_starts got=%0d exp=%0d", nfs, total); end
  endtask

  task automatic test_dwell3();
    logic [10:0] ev, ov;
    logic [3:0]  demux = '0;
    int          fd_cyc = -1, fd_cnt = 0;
    dat[1] = 4'b1100; vld[1] = 1;
    tick();
    vld[1] = 0;
    for (int c = 1; c <= 14; c++) begin
      ev = exp_vec(1); ov = obs_vec(1); checks++;
      if (ov !== ev) begin failures++; $display("FAIL dwell3 cyc=%0d got=%b exp=%b", c, ov, ev); end
      if (chv_o[1]) demux[sel_o[1]] = ser1;
      if (fd_o[1]) begin fd_cnt++; fd_cyc = c; end
      tick();
    end
    checks++;
    if (demux !== 4'b1100) begin failures++; $display("FAIL dwell3_demux got=%b exp=1100", demux); end
    checks++;
    if (fd_cnt != 1 || fd_cyc != 12) begin failures++; $display("FAIL dwell3_done got=%0d@%0d exp=1@12", fd_cnt, fd_cyc); end
  endtask

  task automatic test_hold();
    logic [10:0] ev, ov;
    int          waited = 0;
    dat[0] = 4'b1010; vld[0] = 1;
    tick();
    dat[0] = 4'b1111;
    checks++;
    if (rdy_o[0] !== 1'b0 || mux_o[0] !== 4'b1010) begin
      failures++; $display("FAIL hold_first_beat got=%b/%b exp=0/1010", rdy_o[0], mux_o[0]);
    end
    while (!exp_ready(0) && waited < 20) begin
      ev = exp_vec(0); ov = obs_vec(0); checks++;
      if (ov !== ev) begin failures++; $display("FAIL hold cyc=%0d got=%b exp=%b", waited, ov, ev); end
      tick();
      waited++;
    end
    checks++;
    if (waited != 3) begin failures++; $display("FAIL hold_wait got=%0d exp=3", waited); end
    tick();
    vld[0] = 0;
    checks++;
    if (mux_o[0] !== 4'b1111) begin failures++; $display("FAIL hold_taken got=%b exp=1111", mux_o[0]); end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] ev, ov;
    dat[0] = 4'b1010; vld[0] = 1;
    tick();
    vld[0] = 0;
    tick(); tick();
    checks++;
    if (sel_o[0] !== 2'd2) begin failures++; $display("FAIL midrst_setup got=%0d exp=2", sel_o[0]); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      ev = exp_vec(i); ov = obs_vec(i); checks++;
      if (ov !== ev) begin failures++; $display("FAIL midrst_async[%0d] got=%b exp=%b", i, ov, ev); end
    end
    @(negedge clk);
    checks++;
    if (fd_o[0] !== 1'b0 || chv_o[0] !== 1'b0) begin failures++; $display("FAIL midrst_hold got=%b%b exp=00", fd_o[0], chv_o[0]); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy_o[0] !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", rdy_o[0]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [10:0] ev, ov;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        ev = exp_vec(i); ov = obs_vec(i); checks++;
        if (ov !== ev) begin failures++; $display("FAIL random[%0d] cyc=%0d got=%b exp=%b", i, c, ov, ev); end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 1) == 1);
        dat[i] = 4'($urandom);
      end
    end
    drain();
  endtask

  task automatic test_loopback();
    logic [10:0] ev, ov;
    logic        exp_err;
`ifdef LOOPBACK_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    corrupt = 1;
    dat[0] = 4'b0101; vld[0] = 1;
    tick();
    vld[0] = 0;
    for (int c = 1; c <= 6; c++) begin
      ev = exp_vec(0); ov = obs_vec(0); checks++;
      if (ov !== ev) begin failures++; $display("FAIL loopback cyc=%0d got=%b exp=%b", c, ov, ev); end
      if (c == 2) begin
        checks++;
        if (err_o[0] !== 1'b0) begin failures++; $display("FAIL loopback_early got=%b exp=0", err_o[0]); end
      end
      if (c == 3) begin
        checks++;
        if (err_o[0] !== exp_err) begin failures++; $display("FAIL loopback_flag got=%b exp=%b", err_o[0], exp_err); end
      end
      tick();
    end
    corrupt = 0;
    dat[0] = 4'b0011; vld[0] = 1;
    tick();
    vld[0] = 0;
    for (int c = 1; c <= 6; c++) begin
      ev = exp_vec(0); ov = obs_vec(0); checks++;
      if (ov !== ev) begin failures++; $display("FAIL loopback_sticky cyc=%0d got=%b exp=%b", c, ov, ev); end
      tick();
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (err_o[0] !== 1'b0) begin failures++; $display("FAIL loopback_clear got=%b exp=0", err_o[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    corrupt = 0;
    vld[0] = 0; vld[1] = 0;
    dat[0] = '0; dat[1] = '0;
    model_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_dwell3();
    test_hold();
    test_reset_mid_frame();
    test_random();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
